test_monitor: RTL

- Synthesizable self-check monitor for the 6502 regression suites.
- Snoops CPU data-bus writes and shadows up to NUM_CHECKS result addresses.
- At end of test, triggered by a write to a done address or by a cycle timeout, compares each shadow against its expected value and reports pass/fail with the failing index.
- Generalises the single fixed-address, fixed-time RAM check into a parametrised, bus-driven checker inside top.

---
 rtl/test_mon_pkg.sv | 25 ++
 rtl/test_mon_entry.sv | 57 +++++
 rtl/test_monitor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/test_mon_pkg.sv
// Shared state type, default constants and flattened-vector helper for the
// 6502 regression self-check monitor.
package test_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_t;

  localparam logic [15:0] DEF_DONE_ADDR = 16'hFFF0;
  localparam int          DEF_TIMEOUT   = 32'sd170;
  localparam int          MAX_ENTRIES   = 32'sd16;
  localparam int          MAX_ENTRY_W   = 32'sd32;
  localparam int          MAX_FLAT_W    = MAX_ENTRIES * MAX_ENTRY_W;

  // Entry idx of a flattened vector of width-bit fields; callers narrow the result.
  function automatic logic [MAX_ENTRY_W-1:0] entry_sel(input logic [MAX_FLAT_W-1:0] flat,
                                                        input int unsigned width,
                                                        input int unsigned idx);
    return MAX_ENTRY_W'(flat >> (width * idx));
  endfunction

endpackage

// File: rtl/test_mon_entry.sv
// One checked result address: bus match, shadow copy, written flag and,
// with TEST_MON_WRCOUNT_EN defined, a saturating store counter.
module test_mon_entry
  import test_mon_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              clear,
  input  logic              capture,
  input  logic              enable,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [ADDR_W-1:0] match_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] shadow,
  output logic              written
`ifdef TEST_MON_WRCOUNT_EN
  ,
  output logic [7:0]        wr_count
`endif
);

  logic hit_s;

  assign hit_s = capture & enable & bus_we & (bus_addr == match_addr);

  // Shadow register and written flag; later stores overwrite earlier ones.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      shadow  <= {DATA_W{1'b0}};
      written <= 1'b0;
    end else if (clear) begin
      shadow  <= {DATA_W{1'b0}};
      written <= 1'b0;
    end else if (hit_s) begin
      shadow  <= bus_wdata;
      written <= 1'b1;
    end
  end

`ifdef TEST_MON_WRCOUNT_EN
  // Store counter, saturating so a runaway loop cannot wrap back to one.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      wr_count <= 8'd0;
    end else if (clear) begin
      wr_count <= 8'd0;
    end else if (hit_s && (wr_count != 8'hFF)) begin
      wr_count <= wr_count + 8'd1;
    end
  end
`endif

endmodule

// File: rtl/test_monitor.sv
// Bus-snooping end-of-test checker: shadows result addresses during RUN, then
// compares them one per cycle. TEST_MON_WRCOUNT_EN adds per-entry store counts.
module test_monitor
  import test_mon_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 8,
  parameter int                NUM_CHECKS = 4,
  parameter int                TIMEOUT    = DEF_TIMEOUT,
  parameter logic [ADDR_W-1:0] DONE_ADDR  = ADDR_W'(DEF_DONE_ADDR),
  parameter int                CNT_W      = 16
) (
  input  logic                         ph1,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            bus_addr,
  input  logic [DATA_W-1:0]            bus_wdata,
  input  logic                         bus_we,
  input  logic [NUM_CHECKS*ADDR_W-1:0] chk_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0] chk_expect,
  input  logic [NUM_CHECKS-1:0]        chk_en,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timed_out,
  output logic [3:0]                   fail_idx,
  output logic [DATA_W-1:0]            fail_data,
  output logic [CNT_W-1:0]             cycles
`ifdef TEST_MON_WRCOUNT_EN
  ,
  output logic [NUM_CHECKS*8-1:0]      wr_count
`endif
);

  mon_state_t                   state_r;
  logic [3:0]                   k_r;
  logic [NUM_CHECKS*DATA_W-1:0] shadow_flat_s;
  logic [NUM_CHECKS-1:0]        written_s;
  logic                         clear_s;
  logic                         capture_s;
  logic [DATA_W-1:0]            shadow_k_s;
  logic [DATA_W-1:0]            expect_k_s;
  logic                         written_k_s;
  logic                         en_k_s;
  logic                         fail_s;
`ifdef TEST_MON_WRCOUNT_EN
  logic [7:0]                   wcnt_k_s;
`endif

  assign clear_s   = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign capture_s = (state_r == ST_RUN);

  for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_entry
    test_mon_entry #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_entry (
      .ph1       (ph1),
      .reset     (reset),
      .clear     (clear_s),
      .capture   (capture_s),
      .enable    (chk_en[i]),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .match_addr(ADDR_W'(entry_sel(MAX_FLAT_W'(chk_addr), ADDR_W, i))),
      .bus_wdata (bus_wdata),
      .shadow    (shadow_flat_s[i*DATA_W +: DATA_W]),
      .written   (written_s[i])
`ifdef TEST_MON_WRCOUNT_EN
      ,
      .wr_count  (wr_count[i*8 +: 8])
`endif
    );
  end

  // Fail evaluation for the entry currently addressed by the compare index.
  always_comb begin
    shadow_k_s  = DATA_W'(entry_sel(MAX_FLAT_W'(shadow_flat_s), DATA_W, 32'(k_r)));
    expect_k_s  = DATA_W'(entry_sel(MAX_FLAT_W'(chk_expect), DATA_W, 32'(k_r)));
    written_k_s = |(written_s & (NUM_CHECKS'(1) << k_r));
    en_k_s      = |(chk_en & (NUM_CHECKS'(1) << k_r));
    fail_s      = en_k_s & (~written_k_s | (shadow_k_s != expect_k_s));
`ifdef TEST_MON_WRCOUNT_EN
    wcnt_k_s    = 8'(entry_sel(MAX_FLAT_W'(wr_count), 32'd8, 32'(k_r)));
    fail_s      = fail_s | (en_k_s & (wcnt_k_s > 8'd1));
`endif
  end

  // Run/check sequencer; every status output is a register updated here.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      k_r       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timed_out <= 1'b0;
      fail_idx  <= 4'd0;
      fail_data <= {DATA_W{1'b0}};
      cycles    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r   <= ST_RUN;
            k_r       <= 4'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            timed_out <= 1'b0;
            fail_idx  <= 4'd0;
            fail_data <= {DATA_W{1'b0}};
            cycles    <= {CNT_W{1'b0}};
          end
        end
        ST_RUN: begin
          if (cycles != {CNT_W{1'b1}}) begin
            cycles <= cycles + CNT_W'(1);
          end
          // The done-write takes priority over a coincident timeout.
          if (bus_we && (bus_addr == DONE_ADDR)) begin
            state_r <= ST_CHECK;
          end else if (cycles == CNT_W'(TIMEOUT - 1)) begin
            state_r   <= ST_CHECK;
            timed_out <= 1'b1;
          end
          k_r <= 4'd0;
        end
        ST_CHECK: begin
          if (fail_s) begin
            fail_idx  <= k_r;
            fail_data <= shadow_k_s;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_r   <= ST_DONE;
          end else if (k_r == 4'(NUM_CHECKS - 1)) begin
            pass    <= ~timed_out;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            k_r <= k_r + 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
